coin_credit_unit: RTL and testbench
===================================

Name: coin_credit_unit

Overview:
- Upstream front-end for the vending Main block.
- Accepts coin pulses and a customer selection, then accumulates credit into a 7-bit value.
- Issues one purchase transaction (mode, customer_money, supply_type, customer_amount) to Main and waits for Main's done/error result.
- Returns change or a full refund, then clears for the next customer.

Parameters:
- MAX_CREDIT, 100, highest credit accepted (≤127); any coin that would exceed it is rejected.
- WAIT_TIMEOUT, 15, cycles to wait for main_done before forcing a refund.
- IDLE_TIMEOUT, 63, cycles of no activity in COLLECT before auto-refund (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coin_valid  in  1  one-cycle coin-inserted strobe.
- coin_type  in  2  coin value: 00=1, 01=2, 10=5, 11=10.
- sel_valid  in  1  one-cycle purchase-request strobe.
- sel_type  in  3  requested supply type.
- sel_amount  in  4  requested quantity.
- cancel  in  1  customer cancel strobe.
- main_done  in  1  Main finished the transaction (one cycle).
- main_error  in  7  Main error code; 0 = success.
- main_change  in  7  change owed on success.
- mode  out  2  to Main: 2'b01 while txn_valid is high, else 2'b00.
- customer_money  out  7  latched credit presented to Main.
- supply_type  out  3  latched sel_type.
- customer_amount  out  4  latched sel_amount.
- txn_valid  out  1  one-cycle transaction strobe to Main.
- credit  out  7  live credit total.
- coin_reject  out  1  one-cycle pulse when a coin is rejected.
- refund_valid  out  1  one-cycle refund strobe.
- refund_amount  out  7  amount returned; valid while refund_valid is high.
- busy  out  1  high in ISSUE, WAIT and REFUND.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; timers 0. Reset mid-transaction abandons it silently with no refund pulse.
- States: IDLE, COLLECT, ISSUE, WAIT, REFUND. All transitions occur on the rising clk edge.
- IDLE, credit=0:
  - Accepted coin → COLLECT, with credit = coin value on the next cycle.
  - sel_valid with zero credit is ignored.
  - cancel is ignored.
- COLLECT:
  - Coin accepted when credit + value ≤ MAX_CREDIT. The sum is computed 8 bits wide, so it never wraps.
  - Otherwise coin_reject pulses for one cycle and credit is unchanged.
  - sel_valid: latch sel_type, sel_amount and credit into the outputs → ISSUE.
  - cancel: refund_amount = credit → REFUND.
- Simultaneous events in COLLECT, same cycle, priority cancel > sel_valid > coin:
  - The losing coin is not counted and coin_reject pulses.
  - A losing sel_valid is dropped.
- ISSUE: txn_valid=1 and mode=01 for exactly one cycle → WAIT; the wait counter clears.
- WAIT:
  - Coins are rejected (coin_reject pulses); cancel and sel_valid are ignored.
  - main_done with main_error=0: refund_amount = main_change, clamped to customer_money.
  - main_done with main_error≠0: refund_amount = customer_money.
  - Either main_done case → REFUND.
  - Counter reaching WAIT_TIMEOUT without main_done: refund_amount = customer_money → REFUND.
  - main_done arriving in the same cycle as the timeout counts as done.
- REFUND: refund_valid=1 for one cycle; credit, customer_money, supply_type and customer_amount clear to 0 → IDLE.
- Latency:
  - sel_valid → txn_valid: 1 cycle.
  - main_done → refund_valid: 1 cycle.
  - cancel → refund_valid: 1 cycle.
- Outputs are registered; txn_valid, refund_valid and coin_reject are never high two cycles in a row.

Optional Feature:
- Macro COIN_INACTIVITY_TIMEOUT_EN.
- When defined:
  - An idle counter runs in COLLECT and resets on any accepted coin, rejected coin or sel_valid.
  - Reaching IDLE_TIMEOUT → REFUND of the full credit.
  - cancel arriving on the same cycle gives the same result, a single refund.
- When undefined: no counter is built; COLLECT holds indefinitely.

Test Plan:
- Coins 10,10 then sel_valid(type 0, amt 2); main_done with error 0, change 4 → txn_valid pulse with customer_money=20, mode=01; refund_valid with 4; credit returns to 0.
- Coins summing to 98, then a coin of 5 → coin_reject pulses, credit stays 98; then a coin of 2 → credit=100.
- Credit 15, cancel → refund_valid with 15 one cycle later; state returns to IDLE.
- Credit 20, sel_valid; main_done with error 7'h04 → refund_amount=20.
- Credit 20, sel_valid, no main_done → refund of 20 after WAIT_TIMEOUT cycles; a coin inserted during WAIT gets coin_reject.
- rst_n low during WAIT → outputs 0 immediately, no refund pulse. With COIN_INACTIVITY_TIMEOUT_EN defined: credit 5 left idle for 63 cycles → auto refund of 5.

Source files
------------

// File: rtl/coin_credit_unit_if.sv
// Purchase transaction bus between the coin front-end and Main.
// master = coin front-end, slave = Main.
interface coin_credit_unit_if;
  logic [1:0] mode;
  logic [6:0] customer_money;
  logic [2:0] supply_type;
  logic [3:0] customer_amount;
  logic       txn_valid;
  logic       main_done;
  logic [6:0] main_error;
  logic [6:0] main_change;

  modport master (
    output mode,
    output customer_money,
    output supply_type,
    output customer_amount,
    output txn_valid,
    input  main_done,
    input  main_error,
    input  main_change
  );

  modport slave (
    input  mode,
    input  customer_money,
    input  supply_type,
    input  customer_amount,
    input  txn_valid,
    output main_done,
    output main_error,
    output main_change
  );
endinterface

// File: rtl/coin_credit_unit.sv
// Coin credit front-end: collects coins, issues one purchase to Main, refunds.
// Optional COLLECT inactivity auto-refund: define COIN_INACTIVITY_TIMEOUT_EN.
module coin_credit_unit #(
  parameter int MAX_CREDIT   = 100,
  parameter int WAIT_TIMEOUT = 15,
  parameter int IDLE_TIMEOUT = 63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid_i,
  input  logic [1:0] coin_type_i,
  input  logic       sel_valid_i,
  input  logic [2:0] sel_type_i,
  input  logic [3:0] sel_amount_i,
  input  logic       cancel_i,
  coin_credit_unit_if.master main_if,
  output logic [6:0] credit_o,
  output logic       coin_reject_o,
  output logic       refund_valid_o,
  output logic [6:0] refund_amount_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_ISSUE,
    S_WAIT,
    S_REFUND
  } state_e;

  state_e     state_q;
  logic [6:0] credit_q;
  logic [6:0] money_q;
  logic [2:0] type_q;
  logic [3:0] amount_q;
  logic [1:0] mode_q;
  logic       txn_valid_q;
  logic       coin_reject_q;
  logic       refund_valid_q;
  logic [6:0] refund_amount_q;
  logic       busy_q;
  logic [7:0] wait_cnt_q;

  logic [3:0] coin_val;
  logic [7:0] credit_d;
  logic       coin_ok;
  logic [6:0] change_clamped;
  logic       idle_to;

  always_comb begin
    coin_val = 4'd0;
    unique case (coin_type_i)
      2'b00: coin_val = 4'd1;
      2'b01: coin_val = 4'd2;
      2'b10: coin_val = 4'd5;
      2'b11: coin_val = 4'd10;
    endcase
  end

  // 8-bit sum so a near-full credit can never wrap past the limit
  assign credit_d = {1'b0, credit_q} + {4'b0, coin_val};
  assign coin_ok  = credit_d <= 8'(MAX_CREDIT);

  assign change_clamped =
    (main_if.main_change > money_q) ? money_q : main_if.main_change;

`ifdef COIN_INACTIVITY_TIMEOUT_EN
  logic [7:0] idle_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= 8'd0;
    end else if (state_q != S_COLLECT ||
                 coin_valid_i || sel_valid_i) begin
      idle_cnt_q <= 8'd0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 8'd1;
    end
  end

  assign idle_to = (state_q == S_COLLECT) &&
                   !coin_valid_i && !sel_valid_i &&
                   (idle_cnt_q == 8'(IDLE_TIMEOUT - 1));
`else
  // no counter: COLLECT holds until the customer acts
  assign idle_to = (IDLE_TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      credit_q        <= 7'd0;
      money_q         <= 7'd0;
      type_q          <= 3'd0;
      amount_q        <= 4'd0;
      mode_q          <= 2'b00;
      txn_valid_q     <= 1'b0;
      coin_reject_q   <= 1'b0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= 7'd0;
      busy_q          <= 1'b0;
      wait_cnt_q      <= 8'd0;
    end else begin
      coin_reject_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (coin_valid_i) begin
            if (coin_ok) begin
              credit_q <= credit_d[6:0];
              state_q  <= S_COLLECT;
            end else begin
              coin_reject_q <= 1'b1;
            end
          end
        end

        S_COLLECT: begin
          priority case (1'b1)
            cancel_i || idle_to: begin
              refund_amount_q <= credit_q;
              refund_valid_q  <= 1'b1;
              busy_q          <= 1'b1;
              coin_reject_q   <= coin_valid_i;
              state_q         <= S_REFUND;
            end
            sel_valid_i: begin
              money_q       <= credit_q;
              type_q        <= sel_type_i;
              amount_q      <= sel_amount_i;
              txn_valid_q   <= 1'b1;
              mode_q        <= 2'b01;
              busy_q        <= 1'b1;
              coin_reject_q <= coin_valid_i;
              state_q       <= S_ISSUE;
            end
            coin_valid_i: begin
              if (coin_ok) begin
                credit_q <= credit_d[6:0];
              end else begin
                coin_reject_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end

        S_ISSUE: begin
          txn_valid_q <= 1'b0;
          mode_q      <= 2'b00;
          wait_cnt_q  <= 8'd0;
          state_q     <= S_WAIT;
        end

        S_WAIT: begin
          coin_reject_q <= coin_valid_i;
          if (main_if.main_done) begin
            refund_amount_q <= (main_if.main_error == 7'd0) ?
                               change_clamped : money_q;
            refund_valid_q  <= 1'b1;
            state_q         <= S_REFUND;
          end else if (wait_cnt_q == 8'(WAIT_TIMEOUT - 1)) begin
            refund_amount_q <= money_q;
            refund_valid_q  <= 1'b1;
            state_q         <= S_REFUND;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        S_REFUND: begin
          refund_valid_q  <= 1'b0;
          refund_amount_q <= 7'd0;
          credit_q        <= 7'd0;
          money_q         <= 7'd0;
          type_q          <= 3'd0;
          amount_q        <= 4'd0;
          busy_q          <= 1'b0;
          state_q         <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign main_if.mode            = mode_q;
  assign main_if.customer_money  = money_q;
  assign main_if.supply_type     = type_q;
  assign main_if.customer_amount = amount_q;
  assign main_if.txn_valid       = txn_valid_q;

  assign credit_o        = credit_q;
  assign coin_reject_o   = coin_reject_q;
  assign refund_valid_o  = refund_valid_q;
  assign refund_amount_o = refund_amount_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_coin_credit_unit.sv
// Directed bench for coin_credit_unit.
// Inputs driven 1 time unit after posedge; outputs sampled there too.
module tb_coin_credit_unit;

  localparam int WT = 15;

  logic       clk;
  logic       rst_n;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       sel_valid;
  logic [2:0] sel_type;
  logic [3:0] sel_amount;
  logic       cancel;
  logic [6:0] credit;
  logic       coin_reject;
  logic       refund_valid;
  logic [6:0] refund_amount;
  logic       busy;

  int nchk;
  int nerr;

  coin_credit_unit_if bus ();

  coin_credit_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .coin_valid_i    (coin_valid),
    .coin_type_i     (coin_type),
    .sel_valid_i     (sel_valid),
    .sel_type_i      (sel_type),
    .sel_amount_i    (sel_amount),
    .cancel_i        (cancel),
    .main_if         (bus.master),
    .credit_o        (credit),
    .coin_reject_o   (coin_reject),
    .refund_valid_o  (refund_valid),
    .refund_amount_o (refund_amount),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [2:0] t, input logic [3:0] a);
    sel_valid  = 1'b1;
    sel_type   = t;
    sel_amount = a;
    step();
    sel_valid  = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  task automatic done(input logic [6:0] e, input logic [6:0] c);
    bus.main_done   = 1'b1;
    bus.main_error  = e;
    bus.main_change = c;
    step();
    bus.main_done   = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    bit quiet;
    nchk = 0;
    nerr = 0;
    rst_n = 1'b0;
    coin_valid = 1'b0;
    coin_type = 2'b00;
    sel_valid = 1'b0;
    sel_type = 3'd0;
    sel_amount = 4'd0;
    cancel = 1'b0;
    bus.main_done = 1'b0;
    bus.main_error = 7'd0;
    bus.main_change = 7'd0;
    #22;
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txn", bus.txn_valid, 0);
    chk("rst_refund", refund_valid, 0);
    rst_n = 1'b1;
    step();

    // idle: select and cancel with zero credit do nothing
    select(3'd1, 4'd1);
    chk("idle_sel_txn", bus.txn_valid, 0);
    do_cancel();
    chk("idle_cancel", refund_valid, 0);

    // 10 + 10, buy, success with change 4
    put_coin(2'b11);
    chk("credit10", credit, 10);
    put_coin(2'b11);
    chk("credit20", credit, 20);
    select(3'd0, 4'd2);
    chk("txn_pulse", bus.txn_valid, 1);
    chk("txn_mode", bus.mode, 1);
    chk("txn_money", bus.customer_money, 20);
    chk("txn_amt", bus.customer_amount, 2);
    chk("busy_issue", busy, 1);
    step();
    chk("txn_once", bus.txn_valid, 0);
    chk("mode_back", bus.mode, 0);
    done(7'd0, 7'd4);
    chk("ok_refund_v", refund_valid, 1);
    chk("ok_refund_amt", refund_amount, 4);
    step();
    chk("ok_refund_once", refund_valid, 0);
    chk("ok_credit_clr", credit, 0);
    chk("ok_busy_clr", busy, 0);
    chk("ok_money_clr", bus.customer_money, 0);

    // limit: 98, +5 rejected, +2 reaches 100
    for (int i = 0; i < 9; i++) put_coin(2'b11);
    put_coin(2'b10);
    put_coin(2'b01);
    put_coin(2'b00);
    chk("credit98", credit, 98);
    put_coin(2'b10);
    chk("rej_pulse", coin_reject, 1);
    chk("rej_credit", credit, 98);
    step();
    chk("rej_once", coin_reject, 0);
    put_coin(2'b01);
    chk("credit100", credit, 100);
    do_cancel();
    chk("full_refund", refund_amount, 100);
    step();

    // cancel at 15
    put_coin(2'b11);
    put_coin(2'b10);
    do_cancel();
    chk("cancel_v", refund_valid, 1);
    chk("cancel_amt", refund_amount, 15);
    step();
    chk("cancel_idle", busy, 0);
    chk("cancel_clr", credit, 0);

    // error from Main refunds full money
    put_coin(2'b11);
    put_coin(2'b11);
    select(3'd2, 4'd1);
    step();
    done(7'h04, 7'd3);
    chk("err_refund", refund_amount, 20);
    step();

    // change larger than money is clamped
    put_coin(2'b10);
    select(3'd3, 4'd1);
    step();
    done(7'd0, 7'd9);
    chk("clamp_refund", refund_amount, 5);
    step();

    // timeout with a coin during WAIT
    put_coin(2'b11);
    put_coin(2'b11);
    select(3'd1, 4'd3);
    n = 0;
    step();
    n++;
    put_coin(2'b11);
    n++;
    chk("wait_coin_rej", coin_reject, 1);
    chk("wait_credit", credit, 20);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (refund_valid) seen = 1'b1;
      else begin
        step();
        n++;
      end
    end
    chk("to_seen", seen, 1);
    chk("to_amt", refund_amount, 20);
    chk("to_not_early", (n >= WT && n <= WT + 2), 1);
    step();

    // done on the last wait cycle wins over the timeout
    put_coin(2'b11);
    put_coin(2'b11);
    select(3'd1, 4'd1);
    step();
    for (int i = 0; i < WT - 1; i++) step();
    chk("edge_no_refund", refund_valid, 0);
    done(7'd0, 7'd3);
    chk("edge_done_wins", refund_amount, 3);
    step();

    // cancel beats coin, sel beats coin
    put_coin(2'b11);
    cancel = 1'b1;
    put_coin(2'b11);
    cancel = 1'b0;
    chk("cc_refund", refund_amount, 10);
    chk("cc_reject", coin_reject, 1);
    step();
    put_coin(2'b11);
    coin_valid = 1'b1;
    coin_type = 2'b10;
    select(3'd4, 4'd5);
    coin_valid = 1'b0;
    chk("sc_money", bus.customer_money, 10);
    chk("sc_reject", coin_reject, 1);
    step();
    done(7'd0, 7'd0);
    chk("sc_refund0", refund_amount, 0);
    step();

    // reset during WAIT abandons silently
    put_coin(2'b11);
    put_coin(2'b11);
    select(3'd0, 4'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_credit", credit, 0);
    chk("rw_money", bus.customer_money, 0);
    step();
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < WT + 4; i++) begin
      step();
      if (refund_valid) quiet = 1'b0;
    end
    chk("rw_no_refund", quiet, 1);

`ifdef COIN_INACTIVITY_TIMEOUT_EN
    put_coin(2'b10);
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (refund_valid) seen = 1'b1;
      else step();
    end
    chk("idle_auto_seen", seen, 1);
    chk("idle_auto_amt", refund_amount, 5);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
